divider_nb: RTL and testbench

DIVIDER_NB -- requirements
Module: divider_nb

---
 rtl/divider_nb.sv | 150 +++++++++++++++
 tb/tb_divider_nb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/divider_nb.sv
// divider_nb: multi-cycle restoring divider, one quotient bit per clock.
// Latency is WIDTH+1 cycles from the accepting edge; divide-by-zero
// completes one cycle after acceptance with q = all ones, r = a, dz = 1.
// Optional feature macro: DIVIDER_SIGNED_EN (two's-complement mode via sgn).
// Without it the divider is unsigned only and sgn is ignored.
module divider_nb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             finish,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             zdiv;
    logic             accept;
    logic             ld;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             step_bit;
    logic [WIDTH-1:0] step_rem;

`ifdef DIVIDER_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_q, neg_r;

    // Operand sign detection and magnitude conversion (most-negative maps to 2^(WIDTH-1))
    always_comb begin
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end
`else
    logic unused_sgn;
    assign unused_sgn = sgn;

    // Unsigned build: operands are used as-is
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign ld     = (state == BUSY) && (zdiv || (cnt == CW'(WIDTH)));
    assign busy   = (state == BUSY);
    assign finish = (state == DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? BUSY : IDLE;
            BUSY:    state_nx = ld ? DONE : BUSY;
            DONE:    state_nx = start ? BUSY : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One restoring step: shift in next dividend bit, subtract divisor if it fits
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        diff     = rem_sh - {1'b0, dvs};
        step_bit = ~diff[WIDTH];
        step_rem = step_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end

    // Iteration datapath; on divide-by-zero quo keeps the raw dividend for r
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            zdiv <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else if (accept) begin
            rem  <= '0;
            quo  <= (b == '0) ? a : a_mag;
            dvs  <= b_mag;
            cnt  <= '0;
            zdiv <= (b == '0);
`ifdef DIVIDER_SIGNED_EN
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
`endif
        end else if ((state == BUSY) && !ld) begin
            rem <= step_rem;
            quo <= {quo[WIDTH-2:0], step_bit};
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers: loaded once per completed operation, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= '0;
            r  <= '0;
            dz <= 1'b0;
        end else if (ld) begin
            if (zdiv) begin
                q  <= '1;
                r  <= quo;
                dz <= 1'b1;
            end else begin
`ifdef DIVIDER_SIGNED_EN
                q  <= neg_q ? (~quo + 1'b1) : quo;
                r  <= neg_r ? (~rem + 1'b1) : rem;
`else
                q  <= quo;
                r  <= rem;
`endif
                dz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider_nb.sv
// tb_divider_nb: scoreboard bench for divider_nb (WIDTH=32).
// Stimulus pushes expected results with their completion cycle; a monitor
// pops and compares on every finish pulse.
module tb_divider_nb;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] q, r;
    logic         busy, finish, dz;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int unsigned  cyc;
        string        name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          pass_cnt = 0;
    int          chk_cnt = 0;

    divider_nb #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
        .q(q), .r(r), .busy(busy), .finish(finish), .dz(dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every finish pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && finish) begin
            if (sb.size() == 0) begin
                chk("spurious_finish", 64'(finish), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_q"},    64'(q),    64'(e.q));
                chk({e.name, "_r"},    64'(r),    64'(e.r));
                chk({e.name, "_dz"},   64'(dz),   64'(e.dz));
                chk({e.name, "_cyc"},  64'(cyc),  64'(e.cyc));
                chk({e.name, "_busy"}, 64'(busy), 64'd0);
            end
        end
    end

    task automatic issue(input string nm, input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz, input bit push);
        @(negedge clk);
        sgn = s; a = aa; b = bb; start = 1'b1;
        if (push) sb.push_back('{eq, er, edz, cyc + 1 + (edz ? 1 : W + 1), nm});
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy_after_start"}, 64'(busy), 64'd1);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk({nm, "_drained"}, 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned fin;
        #1 rst = 1'b1;
        #1;
        chk("reset_q", 64'(q), 64'd0);
        chk("reset_r", 64'(r), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_finish", 64'(finish), 64'd0);
        chk("reset_dz", 64'(dz), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue("u10d3", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 1'b1);
        wait_idle("u10d3");

        issue("u7d32", 1'b0, 32'd7, 32'd32, 32'd0, 32'd7, 1'b0, 1'b1);
        a = 32'd99; b = 32'd5;
        wait_idle("u7d32");

        issue("u5d0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b1);
        wait_idle("u5d0");
        repeat (3) @(negedge clk);
        chk("hold_q", 64'(q), 64'hFFFFFFFF);
        chk("hold_r", 64'(r), 64'd5);
        chk("hold_dz", 64'(dz), 64'd1);

        issue("umax1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1);
        wait_idle("umax1");

`ifdef DIVIDER_SIGNED_EN
        issue("s_m7d2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_idle("s_m7d2");
        issue("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1);
        wait_idle("s_ovf");
        issue("s_7dm2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b1);
        wait_idle("s_7dm2");
        issue("s_m5d0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b1);
        wait_idle("s_m5d0");
`else
        issue("sgnign_m7d2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 1'b1);
        wait_idle("sgnign_m7d2");
        issue("sgnign_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b1);
        wait_idle("sgnign_ovf");
`endif

        issue("uffd16", 1'b0, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 32'd15, 1'b0, 1'b1);
        wait_idle("uffd16");

        // Abort a 10/3 operation with an asynchronous reset mid-cycle
        issue("abort", 1'b0, 32'd10, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_q", 64'(q), 64'd0);
        chk("abort_r", 64'(r), 64'd0);
        chk("abort_finish", 64'(finish), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sgn = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        sb.push_back('{32'd14, 32'd2, 1'b0, cyc + 1 + W + 1, "post_rst"});
        @(negedge clk);
        start = 1'b0;
        chk("post_rst_busy", 64'(busy), 64'd1);
        wait_idle("post_rst");

        // Start held through BUSY is ignored; start in the DONE cycle is taken
        @(negedge clk);
        sgn = 1'b0; a = 32'd20; b = 32'd6; start = 1'b1;
        fin = cyc + 1 + W + 1;
        sb.push_back('{32'd3, 32'd2, 1'b0, fin, "b2b_first"});
        @(negedge clk);
        a = 32'd1000; b = 32'd1;
        for (int i = 0; i < 100 && cyc != fin; i++) @(negedge clk);
        chk("b2b_reach_done", 64'(cyc), 64'(fin));
        a = 32'd9; b = 32'd4;
        sb.push_back('{32'd2, 32'd1, 1'b0, cyc + 1 + W + 1, "b2b_second"});
        @(negedge clk);
        start = 1'b0;
        wait_idle("b2b");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
